// File: rtl/dispatch_queue.sv
// Dispatch stage: FIFO of decoded instructions whose head is operand-resolved
// (CDB / ROB-ready / register file) and issued to the RS or LSB, one per cycle.
module dispatch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          NUM_CDB  = 2,
    parameter int          ROB_ID_W = 4,
    parameter int          OP_W     = 6,
    parameter int          NOP_OP   = 0,
    parameter int          LS_LO    = 11,
    parameter int          LS_HI    = 18,
    parameter logic [31:0] IO_ADDR  = 32'h30000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rdy,

    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [OP_W-1:0]             in_openum,
    input  logic [4:0]                  in_rd,
    input  logic [4:0]                  in_rs1,
    input  logic [4:0]                  in_rs2,
    input  logic [31:0]                 in_imm,
    input  logic [31:0]                 in_pc,

    output logic [4:0]                  rs1_to_reg,
    output logic [4:0]                  rs2_to_reg,
    input  logic [31:0]                 V1_from_reg,
    input  logic [31:0]                 V2_from_reg,
    input  logic [ROB_ID_W-1:0]         Q1_from_reg,
    input  logic [ROB_ID_W-1:0]         Q2_from_reg,

    output logic [ROB_ID_W-1:0]         Q1_to_rob,
    output logic [ROB_ID_W-1:0]         Q2_to_rob,
    input  logic                        Q1_ready_from_rob,
    input  logic                        Q2_ready_from_rob,
    input  logic [31:0]                 ready_data1_from_rob,
    input  logic [31:0]                 ready_data2_from_rob,
    input  logic                        rob_full_from_rob,
    input  logic [ROB_ID_W-1:0]         rob_id_from_rob,

    input  logic                        rs_full,
    input  logic                        lsb_full,

    input  logic [NUM_CDB-1:0]          cdb_valid,
    input  logic [NUM_CDB*ROB_ID_W-1:0] cdb_rob_id,
    input  logic [NUM_CDB*32-1:0]       cdb_result,

    input  logic                        commit_jump_flag_from_rob,

    output logic                        ena_to_rob,
    output logic                        ena_to_reg,
    output logic                        ena_to_rs,
    output logic                        ena_to_lsb,
    output logic [4:0]                  rd_out,
    output logic [OP_W-1:0]             openum_out,
    output logic [31:0]                 V1_out,
    output logic [31:0]                 V2_out,
    output logic [ROB_ID_W-1:0]         Q1_out,
    output logic [ROB_ID_W-1:0]         Q2_out,
    output logic [31:0]                 pc_out,
    output logic [31:0]                 imm_out,
    output logic [ROB_ID_W-1:0]         rob_id_out,
    output logic                        is_io_out
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // Lowest-index matching CDB channel wins, then ROB ready data, then the register file.
    function automatic logic [ROB_ID_W+31:0] resolve_src(
        input logic [ROB_ID_W-1:0]         q_reg,
        input logic [31:0]                 v_reg,
        input logic                        rob_rdy,
        input logic [31:0]                 rob_data,
        input logic [NUM_CDB-1:0]          cv,
        input logic [NUM_CDB*ROB_ID_W-1:0] cid,
        input logic [NUM_CDB*32-1:0]       cres
    );
        logic                  hit;
        logic [ROB_ID_W+31:0]  r;
        hit = 1'b0;
        r   = {q_reg, v_reg};
        if (rob_rdy)
            r = {{ROB_ID_W{1'b0}}, rob_data};
        for (int i = 0; i < NUM_CDB; i++) begin
            if (!hit && cv[i] && (q_reg != '0) && (cid[i*ROB_ID_W +: ROB_ID_W] == q_reg)) begin
                hit = 1'b1;
                r   = {{ROB_ID_W{1'b0}}, cres[i*32 +: 32]};
            end
        end
        return r;
    endfunction

    logic [OP_W-1:0]  op_mem_q  [DEPTH];
    logic [4:0]       rd_mem_q  [DEPTH];
    logic [4:0]       rs1_mem_q [DEPTH];
    logic [4:0]       rs2_mem_q [DEPTH];
    logic [31:0]      imm_mem_q [DEPTH];
    logic [31:0]      pc_mem_q  [DEPTH];

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic                ena_q, ena_d, ena_rs_q, ena_rs_d, ena_lsb_q, ena_lsb_d;
    logic [4:0]          rd_q, rd_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [31:0]         v1_q, v1_d, v2_q, v2_d, pc_q, pc_d, imm_q, imm_d;
    logic [ROB_ID_W-1:0] q1_q, q1_d, q2_q, q2_d, rid_q, rid_d;
    logic                io_q, io_d;

    logic [OP_W-1:0]     head_op;
    logic [31:0]         head_imm;
    logic                flush, not_empty, head_is_ls, head_is_nop, target_full;
    logic                go, issue, pop, push;
    logic [31:0]         v1_res, v2_res;
    logic [ROB_ID_W-1:0] q1_res, q2_res;

    assign head_op     = op_mem_q[head_q];
    assign head_imm    = imm_mem_q[head_q];
    assign rs1_to_reg  = rs1_mem_q[head_q];
    assign rs2_to_reg  = rs2_mem_q[head_q];
    assign Q1_to_rob   = Q1_from_reg;
    assign Q2_to_rob   = Q2_from_reg;

    assign flush       = commit_jump_flag_from_rob;
    assign in_ready    = (count_q < CNT_W'(DEPTH));
    assign not_empty   = (count_q != '0);
    assign head_is_ls  = (head_op >= OP_W'(LS_LO)) && (head_op <= OP_W'(LS_HI));
    assign head_is_nop = (head_op == OP_W'(NOP_OP));
    assign target_full = head_is_ls ? lsb_full : rs_full;
    assign go          = rdy && !flush && not_empty;
    assign issue       = go && !head_is_nop && !rob_full_from_rob && !target_full;
    assign pop         = go && (head_is_nop || issue);
    assign push        = in_valid && in_ready && rdy && !flush;

    assign {q1_res, v1_res} = resolve_src(Q1_from_reg, V1_from_reg, Q1_ready_from_rob,
                                          ready_data1_from_rob, cdb_valid, cdb_rob_id, cdb_result);
    assign {q2_res, v2_res} = resolve_src(Q2_from_reg, V2_from_reg, Q2_ready_from_rob,
                                          ready_data2_from_rob, cdb_valid, cdb_rob_id, cdb_result);

    always_ff @(posedge clk) begin
        if (push) begin
            op_mem_q[tail_q]  <= in_openum;
            rd_mem_q[tail_q]  <= in_rd;
            rs1_mem_q[tail_q] <= in_rs1;
            rs2_mem_q[tail_q] <= in_rs2;
            imm_mem_q[tail_q] <= in_imm;
            pc_mem_q[tail_q]  <= in_pc;
        end
    end

    // Pointer/occupancy update; flush overrides everything including a same-cycle push.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push)
                tail_d = tail_q + 1'b1;
            if (pop)
                head_d = head_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        ena_d     = issue;
        ena_rs_d  = issue && !head_is_ls;
        ena_lsb_d = issue && head_is_ls;
        rd_d      = rd_q;
        op_d      = op_q;
        v1_d      = v1_q;
        v2_d      = v2_q;
        q1_d      = q1_q;
        q2_d      = q2_q;
        pc_d      = pc_q;
        imm_d     = imm_q;
        rid_d     = rid_q;
        io_d      = io_q;
        if (issue) begin
            rd_d  = rd_mem_q[head_q];
            op_d  = head_op;
            v1_d  = v1_res;
            v2_d  = v2_res;
            q1_d  = q1_res;
            q2_d  = q2_res;
            pc_d  = pc_mem_q[head_q];
            imm_d = head_imm;
            rid_d = rob_id_from_rob;
            io_d  = head_is_ls && (q1_res == '0) && ((v1_res + head_imm) == IO_ADDR);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            ena_q     <= 1'b0;
            ena_rs_q  <= 1'b0;
            ena_lsb_q <= 1'b0;
            rd_q      <= '0;
            op_q      <= '0;
            v1_q      <= '0;
            v2_q      <= '0;
            q1_q      <= '0;
            q2_q      <= '0;
            pc_q      <= '0;
            imm_q     <= '0;
            rid_q     <= '0;
            io_q      <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            ena_q     <= ena_d;
            ena_rs_q  <= ena_rs_d;
            ena_lsb_q <= ena_lsb_d;
            rd_q      <= rd_d;
            op_q      <= op_d;
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            q1_q      <= q1_d;
            q2_q      <= q2_d;
            pc_q      <= pc_d;
            imm_q     <= imm_d;
            rid_q     <= rid_d;
            io_q      <= io_d;
        end
    end

    assign ena_to_rob = ena_q;
    assign ena_to_reg = ena_q;
    assign ena_to_rs  = ena_rs_q;
    assign ena_to_lsb = ena_lsb_q;
    assign rd_out     = rd_q;
    assign openum_out = op_q;
    assign V1_out     = v1_q;
    assign V2_out     = v2_q;
    assign Q1_out     = q1_q;
    assign Q2_out     = q2_q;
    assign pc_out     = pc_q;
    assign imm_out    = imm_q;
    assign rob_id_out = rid_q;
    assign is_io_out  = io_q;

endmodule

// File: tb/tb_dispatch_queue.sv
// Randomized scoreboard bench for dispatch_queue: a queue-level model predicts
// each issue; a negedge monitor pops and compares whenever the DUT issues.
module tb_dispatch_queue;
    localparam int          DEPTH   = 4;
    localparam logic [31:0] IO_ADDR = 32'h30000;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        in_valid, in_ready;
    logic [5:0]  in_openum;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm, in_pc;
    logic [4:0]  rs1_to_reg, rs2_to_reg;
    logic [31:0] V1_from_reg, V2_from_reg;
    logic [3:0]  Q1_from_reg, Q2_from_reg, Q1_to_rob, Q2_to_rob;
    logic        Q1_ready_from_rob, Q2_ready_from_rob;
    logic [31:0] ready_data1_from_rob, ready_data2_from_rob;
    logic        rob_full_from_rob;
    logic [3:0]  rob_id_from_rob;
    logic        rs_full, lsb_full;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_rob_id;
    logic [63:0] cdb_result;
    logic        commit_jump_flag_from_rob;
    logic        ena_to_rob, ena_to_reg, ena_to_rs, ena_to_lsb;
    logic [4:0]  rd_out;
    logic [5:0]  openum_out;
    logic [31:0] V1_out, V2_out, pc_out, imm_out;
    logic [3:0]  Q1_out, Q2_out, rob_id_out;
    logic        is_io_out;

    always #5 clk = ~clk;

    dispatch_queue dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .in_valid(in_valid), .in_ready(in_ready), .in_openum(in_openum),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_pc(in_pc),
        .rs1_to_reg(rs1_to_reg), .rs2_to_reg(rs2_to_reg),
        .V1_from_reg(V1_from_reg), .V2_from_reg(V2_from_reg),
        .Q1_from_reg(Q1_from_reg), .Q2_from_reg(Q2_from_reg),
        .Q1_to_rob(Q1_to_rob), .Q2_to_rob(Q2_to_rob),
        .Q1_ready_from_rob(Q1_ready_from_rob), .Q2_ready_from_rob(Q2_ready_from_rob),
        .ready_data1_from_rob(ready_data1_from_rob), .ready_data2_from_rob(ready_data2_from_rob),
        .rob_full_from_rob(rob_full_from_rob), .rob_id_from_rob(rob_id_from_rob),
        .rs_full(rs_full), .lsb_full(lsb_full),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_result(cdb_result),
        .commit_jump_flag_from_rob(commit_jump_flag_from_rob),
        .ena_to_rob(ena_to_rob), .ena_to_reg(ena_to_reg), .ena_to_rs(ena_to_rs),
        .ena_to_lsb(ena_to_lsb), .rd_out(rd_out), .openum_out(openum_out),
        .V1_out(V1_out), .V2_out(V2_out), .Q1_out(Q1_out), .Q2_out(Q2_out),
        .pc_out(pc_out), .imm_out(imm_out), .rob_id_out(rob_id_out), .is_io_out(is_io_out)
    );

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm, pc;
    } instr_t;

    typedef struct packed {
        logic        lsb;
        logic [4:0]  rd;
        logic [5:0]  op;
        logic [31:0] v1, v2;
        logic [3:0]  q1, q2;
        logic [31:0] pc, imm;
        logic [3:0]  rid;
        logic        io;
    } exp_t;

    instr_t mq[$];
    exp_t   eq[$];
    exp_t   mon_e;
    int     n_cmp = 0;
    int     n_fail = 0;
    logic   checking = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Source operand as the bypass rules define it: register file, overridden by
    // ROB-ready data, overridden by CDB channel 1, overridden by channel 0.
    function automatic void model_src(input logic [3:0] q, input logic [31:0] v,
                                      input logic rr, input logic [31:0] rdat,
                                      output logic [31:0] vo, output logic [3:0] qo);
        vo = v;
        qo = q;
        if (rr) begin vo = rdat; qo = 4'd0; end
        if (q != 4'd0) begin
            if (cdb_valid[1] && cdb_rob_id[7:4] == q) begin vo = cdb_result[63:32]; qo = 4'd0; end
            if (cdb_valid[0] && cdb_rob_id[3:0] == q) begin vo = cdb_result[31:0];  qo = 4'd0; end
        end
    endfunction

    task automatic drive_idle();
        rdy = 1'b1; in_valid = 1'b0; in_openum = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_imm = '0; in_pc = '0; V1_from_reg = '0; V2_from_reg = '0;
        Q1_from_reg = '0; Q2_from_reg = '0; Q1_ready_from_rob = 1'b0; Q2_ready_from_rob = 1'b0;
        ready_data1_from_rob = '0; ready_data2_from_rob = '0; rob_full_from_rob = 1'b0;
        rob_id_from_rob = '0; rs_full = 1'b0; lsb_full = 1'b0; cdb_valid = '0;
        cdb_rob_id = '0; cdb_result = '0; commit_jump_flag_from_rob = 1'b0;
    endtask

    task automatic drive_rand(input int c);
        int ph;
        ph = c / 400;
        commit_jump_flag_from_rob = ($urandom_range(0, (ph == 3) ? 15 : 60) == 0);
        rdy       = (ph == 2) ? ((c % 9) > 2) : ($urandom_range(0, 9) != 0);
        in_valid  = ($urandom_range(0, 3) != 0);
        in_openum = 6'($urandom_range(0, 40));
        in_rd     = 5'($urandom);
        in_rs1    = 5'($urandom);
        in_rs2    = 5'($urandom);
        in_imm    = (($urandom_range(0, 1) == 0) ? 32'd4 : $urandom);
        in_pc     = $urandom;
        rs_full   = (ph == 1) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0);
        lsb_full  = (ph == 1) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0);
        rob_full_from_rob = ($urandom_range(0, 7) == 0);
        rob_id_from_rob   = 4'($urandom);
        Q1_from_reg = 4'($urandom_range(0, 3));
        Q2_from_reg = 4'($urandom_range(0, 3));
        Q1_ready_from_rob = ($urandom_range(0, 3) == 0);
        Q2_ready_from_rob = ($urandom_range(0, 3) == 0);
        ready_data1_from_rob = $urandom;
        ready_data2_from_rob = $urandom;
        V1_from_reg = $urandom;
        V2_from_reg = $urandom;
        if (mq.size() > 0 && $urandom_range(0, 2) == 0)
            V1_from_reg = IO_ADDR - mq[0].imm;
        cdb_valid  = 2'($urandom);
        cdb_rob_id = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
        cdb_result = {$urandom, $urandom};
    endtask

    // Advance the model by the upcoming clock edge, using the inputs just driven.
    task automatic step();
        instr_t      h, ni;
        exp_t        e;
        logic [31:0] v1, v2;
        logic [3:0]  q1, q2;
        logic        can_in;
        can_in = (mq.size() < DEPTH);
        check("in_ready", in_ready, can_in);
        if (mq.size() > 0) begin
            check("rs1_to_reg", rs1_to_reg, mq[0].rs1);
            check("rs2_to_reg", rs2_to_reg, mq[0].rs2);
        end
        if (commit_jump_flag_from_rob) begin
            mq.delete();
        end else if (rdy) begin
            if (mq.size() > 0) begin
                h = mq[0];
                if (h.op == 6'd0) begin
                    void'(mq.pop_front());
                end else begin
                    e.lsb = (h.op >= 6'd11) && (h.op <= 6'd18);
                    if (!rob_full_from_rob && !(e.lsb ? lsb_full : rs_full)) begin
                        model_src(Q1_from_reg, V1_from_reg, Q1_ready_from_rob, ready_data1_from_rob, v1, q1);
                        model_src(Q2_from_reg, V2_from_reg, Q2_ready_from_rob, ready_data2_from_rob, v2, q2);
                        e.rd = h.rd; e.op = h.op; e.v1 = v1; e.v2 = v2; e.q1 = q1; e.q2 = q2;
                        e.pc = h.pc; e.imm = h.imm; e.rid = rob_id_from_rob;
                        e.io = e.lsb && (q1 == 4'd0) && ((v1 + h.imm) == IO_ADDR);
                        eq.push_back(e);
                        void'(mq.pop_front());
                    end
                end
            end
            if (in_valid && can_in) begin
                ni.op = in_openum; ni.rd = in_rd; ni.rs1 = in_rs1; ni.rs2 = in_rs2;
                ni.imm = in_imm; ni.pc = in_pc;
                mq.push_back(ni);
            end
        end
    endtask

    always @(negedge clk) begin
        if (checking && (ena_to_rob || ena_to_reg || ena_to_rs || ena_to_lsb)) begin
            if (eq.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_issue: got enables %b%b%b%b, expected none",
                         ena_to_rob, ena_to_reg, ena_to_rs, ena_to_lsb);
            end else begin
                mon_e = eq.pop_front();
                check("ena_to_rob", ena_to_rob, 1'b1);
                check("ena_to_reg", ena_to_reg, 1'b1);
                check("ena_to_rs", ena_to_rs, !mon_e.lsb);
                check("ena_to_lsb", ena_to_lsb, mon_e.lsb);
                check("is_io_out", is_io_out, mon_e.io);
                check("payload",
                      {rd_out, openum_out, V1_out, V2_out, Q1_out, Q2_out, pc_out, imm_out, rob_id_out},
                      {mon_e.rd, mon_e.op, mon_e.v1, mon_e.v2, mon_e.q1, mon_e.q2, mon_e.pc, mon_e.imm, mon_e.rid});
            end
        end
    end

    initial begin
        rst = 1'b1;
        drive_idle();
        repeat (3) @(posedge clk);
        #1;
        check("reset_enables", {ena_to_rob, ena_to_reg, ena_to_rs, ena_to_lsb}, 4'b0000);
        check("reset_payload",
              {rd_out, openum_out, V1_out, V2_out, Q1_out, Q2_out, pc_out, imm_out, rob_id_out, is_io_out}, '0);
        check("reset_in_ready", in_ready, 1'b1);
        rst = 1'b0;
        checking = 1'b1;
        for (int c = 0; c < 1600; c++) begin
            @(posedge clk);
            #1;
            drive_rand(c);
            step();
        end
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            drive_idle();
            step();
        end
        @(negedge clk);
        check("drain_pending", eq.size(), 0);
        check("drain_in_ready", in_ready, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
